// File: rtl/seq_detect_param.sv
// Serial MSB-first pattern detector with a runtime-loadable pattern, overlap control and a one-cycle registered match pulse.
// Define SEQ_DETECT_CNT_EN to build the saturating match counter; otherwise o_match_cnt is tied to zero.
module seq_detect_param #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PAT_RST = 3'b011,
    parameter int               CNT_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ins,
    input  logic             i_in_valid,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic             i_pat_load,
    input  logic             i_overlap_en,
    input  logic             i_cnt_clr,
    output logic             o_outs,
    output logic [CNT_W-1:0] o_match_cnt,
    output logic [1:0]       o_state
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_ARMED = 2'd2;

    logic [PAT_W-1:0]  r_pat;
    logic [PAT_W-1:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic              r_outs;

    logic              w_accept;
    logic [PAT_W-1:0]  w_hist_nxt;
    logic [FILL_W-1:0] w_fill_nxt;
    logic              w_match;

    // A load in the same cycle as a valid bit wins; that bit is dropped.
    assign w_accept   = i_in_valid & ~i_pat_load;
    assign w_hist_nxt = {r_hist[PAT_W-2:0], i_ins};
    assign w_fill_nxt = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;
    assign w_match    = w_accept && (w_fill_nxt == FILL_FULL) && (w_hist_nxt == r_pat);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pat  <= PAT_RST;
            r_hist <= '0;
            r_fill <= '0;
            r_outs <= 1'b0;
        end else if (i_pat_load) begin
            r_pat  <= i_pattern;
            r_hist <= '0;
            r_fill <= '0;
            r_outs <= 1'b0;
        end else if (w_accept) begin
            r_outs <= w_match;
            // Non-overlapping mode restarts from empty so no matched bit is reused.
            if (w_match && !i_overlap_en) begin
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                r_hist <= w_hist_nxt;
                r_fill <= w_fill_nxt;
            end
        end else begin
            r_outs <= 1'b0;
        end
    end

    always_comb begin
        o_state = ST_FILL;
        if (r_fill == '0) begin
            o_state = ST_IDLE;
        end else if (r_fill == FILL_FULL) begin
            o_state = ST_ARMED;
        end
    end

    assign o_outs = r_outs;

`ifdef SEQ_DETECT_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Clear beats a coincident match; the count sticks at all-ones.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_match_cnt = r_cnt;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = i_cnt_clr;
    assign o_match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed vector table, a saturation sequence on a small instance,
// and random traffic checked against a queue-based reference model.
module tb_seq_detect_param;

`ifdef SEQ_DETECT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // ---------------- clock / reset / signals ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ins, in_valid, pat_load, overlap_en, cnt_clr;
    logic [2:0] pattern;
    logic       outs;
    logic [7:0] match_cnt;
    logic [1:0] state;

    logic       s_ins, s_in_valid, s_pat_load, s_overlap_en, s_cnt_clr;
    logic [1:0] s_pattern;
    logic       s_outs;
    logic [1:0] s_match_cnt;
    logic [1:0] s_state;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(3), .PAT_RST(3'b011), .CNT_W(8)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ins(ins), .i_in_valid(in_valid),
        .i_pattern(pattern), .i_pat_load(pat_load), .i_overlap_en(overlap_en),
        .i_cnt_clr(cnt_clr), .o_outs(outs), .o_match_cnt(match_cnt), .o_state(state)
    );

    seq_detect_param #(.PAT_W(2), .PAT_RST(2'b11), .CNT_W(2)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_ins(s_ins), .i_in_valid(s_in_valid),
        .i_pattern(s_pattern), .i_pat_load(s_pat_load), .i_overlap_en(s_overlap_en),
        .i_cnt_clr(s_cnt_clr), .o_outs(s_outs), .o_match_cnt(s_match_cnt), .o_state(s_state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int idx, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s #%0d: got %0d, expected %0d", name, idx, got, exp);
        end
    endtask

    // ---------------- reference model (main instance) ----------------
    bit   m_q[$];
    int   m_pat = 3;
    bit   m_out = 1'b0;
    int   m_cnt = 0;
    logic [7:0] exp_q[$];

    function automatic int q_value();
        int v = 0;
        foreach (m_q[i]) v = (v << 1) | int'(m_q[i]);
        return v;
    endfunction

    task automatic model_step(input bit r, input bit v, input bit b, input bit ld,
                              input int p, input bit ov, input bit clr);
        bit hit = 1'b0;
        if (!r) begin
            m_pat = 3; m_q.delete(); m_out = 1'b0; m_cnt = 0;
        end else begin
            if (ld) begin
                m_pat = p; m_q.delete(); m_out = 1'b0;
            end else if (v) begin
                m_q.push_back(b);
                if (m_q.size() > 3) void'(m_q.pop_front());
                hit = (m_q.size() == 3) && (q_value() == m_pat);
                m_out = hit;
                if (hit && !ov) m_q.delete();
            end else begin
                m_out = 1'b0;
            end
            if (clr) m_cnt = 0;
            else if (hit && m_cnt < 255) m_cnt++;
        end
        exp_q.push_back(CNT_EN ? 8'(m_cnt) : 8'd0);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic v, input logic b, input logic ld,
                        input logic [2:0] p, input logic ov, input logic clr);
        rst_n = r; in_valid = v; ins = b; pat_load = ld; pattern = p;
        overlap_en = ov; cnt_clr = clr;
        model_step(r, v, b, ld, int'(p), ov, clr);
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       r, v, b, ld;
        logic [2:0] p;
        logic       ov, clr;
        logic       e_out;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic b, input logic ld,
                       input logic [2:0] p, input logic ov, input logic clr,
                       input logic e_out, input logic [7:0] e_cnt);
        vec_t t;
        t.r = r; t.v = v; t.b = b; t.ld = ld; t.p = p; t.ov = ov; t.clr = clr;
        t.e_out = e_out; t.e_cnt = e_cnt;
        vecs.push_back(t);
    endtask

    initial begin
        logic [7:0] e;
        s_ins = 0; s_in_valid = 0; s_pat_load = 0; s_overlap_en = 1; s_cnt_clr = 0; s_pattern = 2'b11;

        // reset then default pattern 011
        add(0,0,0,0,0,1,0, 0,0);
        add(0,0,0,0,0,1,0, 0,0);
        add(1,1,0,0,0,1,0, 0,0);
        add(1,1,1,0,0,1,0, 0,0);
        add(1,1,1,0,0,1,0, 1,1);
        add(1,0,0,0,0,1,0, 0,1);
        // 101 with overlap: two pulses
        add(1,0,0,1,5,1,0, 0,1);
        add(1,1,1,0,0,1,0, 0,1);
        add(1,1,0,0,0,1,0, 0,1);
        add(1,1,1,0,0,1,0, 1,2);
        add(1,1,0,0,0,1,0, 0,2);
        add(1,1,1,0,0,1,0, 1,3);
        add(1,0,0,0,0,1,0, 0,3);
        add(1,0,0,0,0,1,1, 0,0);
        // 101 without overlap: one pulse
        add(1,0,0,1,5,0,0, 0,0);
        add(1,1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0,0, 0,0);
        add(1,1,1,0,0,0,0, 1,1);
        add(1,1,0,0,0,0,0, 0,1);
        add(1,1,1,0,0,0,0, 0,1);
        add(1,0,0,0,0,0,0, 0,1);
        // valid gaps
        add(1,0,0,1,3,1,0, 0,1);
        add(1,1,0,0,0,1,0, 0,1);
        for (int i = 0; i < 3; i++) add(1,0,1,0,0,1,0, 0,1);
        add(1,1,1,0,0,1,0, 0,1);
        for (int i = 0; i < 3; i++) add(1,0,0,0,0,1,0, 0,1);
        add(1,1,1,0,0,1,0, 1,2);
        for (int i = 0; i < 3; i++) add(1,0,1,0,0,1,0, 0,2);
        // pat_load mid-stream drops the coincident bit
        add(1,0,0,1,3,1,0, 0,2);
        add(1,1,0,0,0,1,0, 0,2);
        add(1,1,1,0,0,1,0, 0,2);
        add(1,1,1,1,6,1,0, 0,2);
        add(1,1,1,0,0,1,0, 0,2);
        add(1,1,1,0,0,1,0, 0,2);
        add(1,1,0,0,0,1,0, 1,3);
        add(1,0,0,0,0,1,0, 0,3);
        // reset mid-stream restores 011 and discards history
        add(1,0,0,1,6,1,0, 0,3);
        add(1,1,0,0,0,1,0, 0,3);
        add(1,1,1,0,0,1,0, 0,3);
        add(0,1,1,0,0,1,0, 0,0);
        add(1,1,1,0,0,1,0, 0,0);
        add(1,1,0,0,0,1,0, 0,0);
        add(1,1,1,0,0,1,0, 0,0);
        add(1,1,1,0,0,1,0, 1,1);
        add(1,0,0,0,0,1,0, 0,1);

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].v, vecs[i].b, vecs[i].ld, vecs[i].p, vecs[i].ov, vecs[i].clr);
            e = CNT_EN ? vecs[i].e_cnt : 8'd0;
            check("vec outs", i, int'(outs), int'(vecs[i].e_out));
            check("vec match_cnt", i, int'(match_cnt), int'(e));
        end

        // saturation on the 2-bit counter instance, pattern 11
        begin
            int so[8] = '{0,1,1,1,1,1,1,0};
            int sc[8] = '{0,1,2,3,3,3,0,0};
            for (int i = 0; i < 8; i++) begin
                s_in_valid = (i < 7);
                s_ins      = 1'b1;
                s_cnt_clr  = (i == 6);
                step(1,0,0,0,0,1,0);
                check("sat outs", i, int'(s_outs), so[i]);
                check("sat match_cnt", i, int'(s_match_cnt), CNT_EN ? sc[i] : 0);
            end
            s_in_valid = 0; s_cnt_clr = 0;
        end

        // random traffic against the model
        exp_q.delete();
        for (int i = 0; i < 800; i++) begin
            logic [7:0] ec;
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 9) < 7),
                 1'($urandom),
                 ($urandom_range(0, 32) == 0),
                 3'($urandom),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0));
            ec = exp_q.pop_back();
            exp_q.delete();
            check("rnd outs", i, int'(outs), int'(m_out));
            check("rnd match_cnt", i, int'(match_cnt), int'(ec));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector. Compares an MSB-first serial bit stream against a runtime-loadable PAT_W-bit pattern and emits a one-cycle registered match pulse. Supports overlapping or non-overlapping detection, per-bit valid qualification and an optional saturating match counter. Sits between the serial front end and the control logic that consumes match events.

## Interface
- PAT_W, 3: pattern length in bits; legal range 2..16.
- PAT_RST, 3'b011: pattern loaded at reset, PAT_W bits wide.
- CNT_W, 8: match counter width; legal range 1..32.

- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ins  in  1  serial data bit.
- in_valid  in  1  ins is accepted on an edge only when this is high.
- pattern  in  PAT_W  new pattern, sampled when pat_load=1.
- pat_load  in  1  load pattern and clear the detection history.
- overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- outs  out  1  match pulse, registered.
- match_cnt  out  CNT_W  saturating count of matches.

## Operation
- Registers:
  - pat_reg[PAT_W-1:0].
  - hist[PAT_W-1:0], a shift register.
  - fill, a counter 0..PAT_W.
  - outs.
  - match_cnt.
- FSM is derived from fill:
  - IDLE: fill=0.
  - FILL: 0<fill<PAT_W.
  - ARMED: fill=PAT_W.
- Bit acceptance (in_valid=1, pat_load=0):
  - hist_nxt = {hist[PAT_W-2:0], ins}. The first bit received aligns with pattern MSB.
  - fill_nxt = min(fill+1, PAT_W).
- Match condition: fill_nxt==PAT_W and hist_nxt==pat_reg.
- On a match:
  - outs<=1.
  - match_cnt increments.
  - If overlap_en=1: hist<=hist_nxt and fill stays at PAT_W (state ARMED).
  - If overlap_en=0: hist<=0 and fill<=0 (state IDLE). No bit of a matched window is reused.
- No match: hist<=hist_nxt, fill<=fill_nxt, outs<=0.
- in_valid=0: hist and fill hold; outs<=0.
- pat_load=1:
  - pat_reg<=pattern, hist<=0, fill<=0, outs<=0.
  - This has priority over in_valid; a bit presented in the same cycle is dropped.
- overlap_en is sampled on every match edge. Changing it mid-stream affects only subsequent matches.
- match_cnt:
  - Saturates at all-ones; it never wraps.
  - cnt_clr=1 sets it to 0.
  - If cnt_clr and a match occur on the same edge, clear wins and the result is 0.
- Reset (rst_n=0 at an edge):
  - pat_reg<=PAT_RST, hist<=0, fill<=0, outs<=0, match_cnt<=0.
  - Reset overrides every other input. A reset mid-stream discards the partial history.

## Timing
- Latency: outs is high in the cycle after the edge that accepts the completing bit. It stays high exactly one cycle unless the next accepted bit also completes a match.
- Back-to-back matches are possible only with overlap_en=1. Example: PAT=11, stream 1,1,1 gives outs high on consecutive cycles.
- match_cnt updates on the same edge that sets outs.
- Minimum bits from IDLE to the first match: PAT_W accepted bits.
- A new pattern applies from the first bit accepted after the pat_load edge.
- No combinational path from any input to any output.

## Configuration
- SEQ_DETECT_CNT_EN defined:
  - match_cnt register and saturation logic are built.
  - cnt_clr is functional.
- SEQ_DETECT_CNT_EN undefined:
  - No counter logic is built.
  - match_cnt is tied to 0 and cnt_clr is ignored.
  - outs behaviour is identical in both builds.

## Test plan
1. Reset and detect: hold rst_n=0 for 2 cycles, then default PAT=011 and stream 0,1,1 with in_valid=1. Required: outs=0 and match_cnt=0 during reset, outs=1 for exactly one cycle one edge after the third bit, match_cnt=1.
2. Overlap: load PAT=101 and send 1,0,1,0,1. Required: overlap_en=1 gives 2 outs pulses and match_cnt=2; overlap_en=0 gives 1 pulse and match_cnt=1.
3. Valid gaps: PAT=011 with bits 0,1,1 separated by 3 in_valid=0 cycles each. Required: a single match, with no outs pulse during the gap cycles.
4. pat_load mid-stream: after 0,1 with PAT=011, pulse pat_load with pattern=110 while in_valid=1. Required: the same-cycle bit is dropped and no match occurs until 1,1,0 arrives after the load.
5. Saturation and clear: CNT_W=2, PAT=11, overlap_en=1, stream six 1s. Required: match_cnt stops at 3, and cnt_clr on a match edge gives 0. With SEQ_DETECT_CNT_EN undefined, match_cnt stays 0 throughout.
6. Reset mid-stream: send 0,1, assert rst_n=0 for one edge, then send 1. Required: no match and pat_reg returns to 011. A subsequent 0,1,1 produces a match.
